// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and widths for the risc boot loader
package risc_pkg;

   localparam int RISC_ADDR_W = 7;
   localparam int RISC_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN   = 3'd1,
      LOAD  = 3'd2,
      CHK   = 3'd3,
      RUN   = 3'd4,
      ERROR = 3'd5
   } loader_state_t;

endpackage

// File: rtl/sync_rise.sv
// rtl/sync_rise.sv - pin synchronizer with registered single-cycle rising-edge pulse
module sync_rise #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
         r_prev <= r_sync[SYNC_STAGES-1];
         r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      end
   end

   assign rise = r_rise;

endmodule

// File: rtl/risc_prog_loader.sv
// rtl/risc_prog_loader.sv - length-prefixed, checksummed program loader holding the CPU in reset
module risc_prog_loader
   import risc_pkg::*;
#(
   parameter int ADDR_W      = RISC_ADDR_W,
   parameter int DATA_W      = RISC_DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] host_data,
   input  logic              host_strobe,
   input  logic              host_load,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              load_error
);

   logic w_strobe_rise;
   logic w_load_rise;

   sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_strobe (
      .clk      (clk),
      .rst      (rst),
      .async_in (host_strobe),
      .rise     (w_strobe_rise)
   );

   sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
      .clk      (clk),
      .rst      (rst),
      .async_in (host_load),
      .rise     (w_load_rise)
   );

   loader_state_t     r_state, w_state_nx;
   logic [ADDR_W-1:0] r_len, w_len_nx;
   logic [ADDR_W-1:0] r_count, w_count_nx;
   logic [DATA_W-1:0] r_sum, w_sum_nx;
   logic              r_mem_we, w_mem_we_nx;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nx;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nx;

   logic              w_len_ok;
   logic [ADDR_W-1:0] w_count_inc;
   logic [DATA_W-1:0] w_sum_add;

   // A length byte must fit the address space and be non-zero.
   assign w_len_ok    = (host_data[DATA_W-1:ADDR_W] == '0) && (host_data[ADDR_W-1:0] != '0);
   assign w_count_inc = r_count + ADDR_W'(1);
   assign w_sum_add   = r_sum + host_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_count     <= '0;
         r_sum       <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_len       <= w_len_nx;
         r_count     <= w_count_nx;
         r_sum       <= w_sum_nx;
         r_mem_we    <= w_mem_we_nx;
         r_mem_addr  <= w_mem_addr_nx;
         r_mem_wdata <= w_mem_wdata_nx;
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_len_nx       = r_len;
      w_count_nx     = r_count;
      w_sum_nx       = r_sum;
      w_mem_we_nx    = 1'b0;
      w_mem_addr_nx  = r_mem_addr;
      w_mem_wdata_nx = r_mem_wdata;
      // A load request discards any byte arriving in the same cycle.
      if (w_load_rise) begin
         w_state_nx = LEN;
         w_sum_nx   = '0;
         w_count_nx = '0;
      end else if (w_strobe_rise) begin
         case (r_state)
            LEN: begin
               if (w_len_ok) begin
                  w_len_nx      = host_data[ADDR_W-1:0];
                  w_mem_addr_nx = '0;
                  w_state_nx    = LOAD;
               end else begin
                  w_state_nx = ERROR;
               end
            end
            LOAD: begin
               w_mem_we_nx    = 1'b1;
               w_mem_addr_nx  = r_count;
               w_mem_wdata_nx = host_data;
               w_sum_nx       = w_sum_add;
               w_count_nx     = w_count_inc;
               if (w_count_inc == r_len) begin
                  w_state_nx = CHK;
               end
            end
            CHK: begin
               w_state_nx = (w_sum_add == '0) ? RUN : ERROR;
            end
            default: ;
         endcase
      end
   end

   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign cpu_rst_n  = (r_state == RUN);
   assign busy       = (r_state == LEN) || (r_state == LOAD) || (r_state == CHK);
   assign load_error = (r_state == ERROR);

endmodule

// File: tb/tb_risc_prog_loader.sv
// tb/tb_risc_prog_loader.sv - self-checking bench for risc_prog_loader
module tb_risc_prog_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] host_data;
   logic       host_strobe;
   logic       host_load;
   logic       mem_we;
   logic [6:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_rst_n;
   logic       busy;
   logic       load_error;

   risc_prog_loader #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .host_data   (host_data),
      .host_strobe (host_strobe),
      .host_load   (host_load),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .cpu_rst_n   (cpu_rst_n),
      .busy        (busy),
      .load_error  (load_error)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   int         we_total = 0;
   logic [7:0] wq_addr[$];
   logic [7:0] wq_data[$];

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wq_addr.push_back({1'b0, mem_addr});
         wq_data.push_back(mem_wdata);
         we_total++;
      end
   end

   typedef struct {
      int         n;
      logic [7:0] b [5];
      int         ew;
      bit         run;
      bit         err;
   } vec_t;

   vec_t vecs [6];

   function automatic vec_t mk(int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                               logic [7:0] b3, logic [7:0] b4, int ew, bit run, bit err);
      vec_t v;
      v.n = n;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
      v.ew = ew; v.run = run; v.err = err;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(logic [7:0] b);
      host_data   = b;
      host_strobe = 1'b1;
      cyc(5);
      host_strobe = 1'b0;
      cyc(5);
   endtask

   task automatic pulse_load();
      host_load = 1'b1;
      cyc(5);
      host_load = 1'b0;
      cyc(5);
   endtask

   task automatic clear_q();
      wq_addr.delete();
      wq_data.delete();
   endtask

   initial begin
      int         lat;
      int         kd;
      logic       bz;
      int         base;
      logic [7:0] sum;
      logic [7:0] d;

      vecs[0] = mk(5, 8'h03, 8'h10, 8'h20, 8'h30, 8'hA0, 3, 1'b1, 1'b0);
      vecs[1] = mk(5, 8'h03, 8'h10, 8'h20, 8'h30, 8'hA1, 3, 1'b0, 1'b1);
      vecs[2] = mk(1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1);
      vecs[3] = mk(1, 8'h85, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, 1'b1);
      vecs[4] = mk(3, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 1'b1, 1'b0);
      vecs[5] = mk(4, 8'h02, 8'h80, 8'h7F, 8'h01, 8'h00, 2, 1'b1, 1'b0);

      rst = 1'b1; host_data = 8'h00; host_strobe = 1'b0; host_load = 1'b0;
      cyc(5);
      rst = 1'b0;
      cyc(50);
      check("reset cpu_rst_n", cpu_rst_n, 0);
      check("reset busy", busy, 0);
      check("reset load_error", load_error, 0);
      check("reset mem_addr", mem_addr, 0);
      check("reset mem_wdata", mem_wdata, 0);
      check("reset no mem_we", we_total, 0);

      for (int v = 0; v < 6; v++) begin
         clear_q();
         pulse_load();
         check($sformatf("v%0d busy after load", v), busy, 1);
         check($sformatf("v%0d error cleared", v), load_error, 0);
         check($sformatf("v%0d cpu held", v), cpu_rst_n, 0);
         for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[i]);
         cyc(3);
         check($sformatf("v%0d write count", v), wq_addr.size(), vecs[v].ew);
         for (int i = 0; i < vecs[v].ew && i < wq_addr.size(); i++) begin
            check($sformatf("v%0d addr%0d", v, i), wq_addr[i], i);
            check($sformatf("v%0d data%0d", v, i), wq_data[i], vecs[v].b[i+1]);
         end
         check($sformatf("v%0d cpu_rst_n", v), cpu_rst_n, vecs[v].run);
         check($sformatf("v%0d load_error", v), load_error, vecs[v].err);
         check($sformatf("v%0d busy idle", v), busy, 0);
      end

      clear_q();
      pulse_load();
      send_byte(8'h01);
      host_data = 8'h99;
      host_strobe = 1'b1;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (mem_we && lat == 0) lat = k;
      end
      host_strobe = 1'b0;
      cyc(5);
      check("write latency edges", lat, 4);
      send_byte(8'h67);
      cyc(2);
      check("latency seq run", cpu_rst_n, 1);

      host_load = 1'b1;
      kd = 0; bz = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (!cpu_rst_n && kd == 0) begin
            kd = k;
            bz = busy;
         end
      end
      host_load = 1'b0;
      cyc(5);
      check("load in RUN drop edge", kd, 4);
      check("load in RUN busy at drop", bz, 1);

      clear_q();
      send_byte(8'h02);
      base = we_total;
      host_data = 8'h55;
      host_strobe = 1'b1;
      host_load = 1'b1;
      cyc(5);
      host_strobe = 1'b0;
      host_load = 1'b0;
      cyc(5);
      check("coincident no write", we_total - base, 0);
      check("coincident busy", busy, 1);
      send_byte(8'h01);
      send_byte(8'h42);
      send_byte(8'hBE);
      cyc(2);
      check("post coincident writes", wq_addr.size(), 1);
      if (wq_addr.size() > 0) check("post coincident data", wq_data[0], 8'h42);
      check("post coincident run", cpu_rst_n, 1);

      clear_q();
      pulse_load();
      send_byte(8'h03);
      send_byte(8'h11);
      send_byte(8'h22);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      check("rst mid busy", busy, 0);
      check("rst mid cpu", cpu_rst_n, 0);
      check("rst mid err", load_error, 0);
      send_byte(8'h33);
      send_byte(8'h9A);
      cyc(2);
      check("rst mid writes", wq_addr.size(), 2);
      check("rst mid still held", cpu_rst_n, 0);
      check("rst mid idle", busy, 0);

      clear_q();
      pulse_load();
      send_byte(8'h7F);
      sum = 8'h00;
      for (int i = 0; i < 127; i++) begin
         d = 8'((i * 3 + 5) & 8'hFF);
         sum = sum + d;
         send_byte(d);
      end
      send_byte(8'h00 - sum);
      cyc(2);
      check("max writes", wq_addr.size(), 127);
      for (int i = 0; i < 127 && i < wq_addr.size(); i++) begin
         d = 8'((i * 3 + 5) & 8'hFF);
         if (wq_addr[i] !== 8'(i) || wq_data[i] !== d) begin
            check($sformatf("max addr%0d", i), wq_addr[i], i);
            check($sformatf("max data%0d", i), wq_data[i], d);
         end
      end
      if (wq_addr.size() == 127) check("max last addr", wq_addr[126], 8'd126);
      check("max run", cpu_rst_n, 1);
      check("max busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/risc_prog_loader.md
# risc_prog_loader

Boot sequencer that sits between the chip pins and the `risc` core. It holds the CPU in reset while a host streams a length-prefixed, checksummed program byte-by-byte over the pins. It writes each byte into the CPU instruction memory through the memory's write port (`we`/address/data), then releases the CPU only if the checksum verifies. It replaces direct pin-driven instruction writes: the CPU can never run a half-written or corrupted program.

## Interface
- `ADDR_W`, 7, instruction memory address width; max program length 2^ADDR_W−1
- `DATA_W`, 8, instruction byte width
- `SYNC_STAGES`, 2, flops in each pin synchronizer (≥2)

- `clk`  in  1  single clock domain
- `rst`  in  1  synchronous, active-high reset
- `host_data`  in  DATA_W  byte from pins; stable while strobe is high
- `host_strobe`  in  1  asynchronous; each rising edge presents one byte
- `host_load`  in  1  asynchronous; rising edge starts a new load from any state
- `mem_we`  out  1  one-cycle write pulse to instruction memory
- `mem_addr`  out  ADDR_W  write address
- `mem_wdata`  out  DATA_W  write data
- `cpu_rst_n`  out  1  active-low reset to `risc`; high only in RUN
- `busy`  out  1  high in LEN, LOAD, CHK
- `load_error`  out  1  high in ERROR

## Operation
- States: IDLE, LEN, LOAD, CHK, RUN, ERROR.
- After `rst`:
  - state IDLE.
  - All outputs 0: `cpu_rst_n`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `load_error`=0.
  - Internal `len`, `count`, `sum` cleared.
- A `host_load` event in any state goes to LEN and clears `sum` and `count`. `cpu_rst_n` goes low in the same cycle as the transition, and any error is cleared.
- A `host_strobe` event (synchronized rising edge) latches `host_data` and is the only way a state consumes a byte. Strobe events in IDLE, RUN and ERROR are ignored.
- LEN, on a byte:
  - bit 7 (MSB) ≠ 0 or low bits == 0 → ERROR.
  - otherwise `len` = byte[ADDR_W−1:0], `mem_addr` = 0 → LOAD.
- LOAD, on a byte:
  - `mem_we` pulses with `mem_addr` = `count` and `mem_wdata` = byte.
  - `sum` = (`sum` + byte) mod 2^DATA_W; `count` += 1.
  - When `count` reaches `len` → CHK.
- CHK, on a byte: if (`sum` + byte) mod 2^DATA_W == 0 → RUN, otherwise → ERROR.
- RUN: `cpu_rst_n` = 1 and stays so until `host_load` or `rst`.
- ERROR: `load_error` = 1 and `cpu_rst_n` = 0. Memory contents are left as written. Exit only via `host_load` or `rst`.
- Address never wraps: the largest `len` is 2^ADDR_W−1, so the highest address written is 2^ADDR_W−2.

## Timing
- Each pin passes through SYNC_STAGES flops, then a previous-value flop for edge detection.
- An event is internally valid SYNC_STAGES+1 edges after the first `clk` edge that samples the pin high.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. They are high/valid for exactly one cycle, starting the cycle after the internal event.
- Host rules:
  - `host_strobe` high and low times are each ≥ SYNC_STAGES+2 cycles.
  - `host_data` is stable from the strobe rise until the strobe falls.
  - `host_load` pulse width is ≥ SYNC_STAGES+2 cycles.
- State and status outputs update on the edge following the internal event.
- A `host_load` event and a strobe event in the same cycle: load wins and the byte is discarded (no `mem_we`).
- `rst` mid-load: back to IDLE the next edge and the CPU stays held. No further writes occur; bytes already written remain.
- `rst` takes priority over all events.

## Structure
- Shared package `risc_pkg`:
  - `loader_state_t` enum (IDLE, LEN, LOAD, CHK, RUN, ERROR).
  - `RISC_ADDR_W` = 7 and `RISC_DATA_W` = 8 constants, used as the parameter defaults.
- Sub-module `sync_rise`:
  - parameter SYNC_STAGES; ports `clk`, `rst`, `async_in`, `rise`.
  - instantiated once for `host_strobe` and once for `host_load`.
- The top-level wrapper drives the CPU write port from `mem_*` and the CPU `rst_n` from `cpu_rst_n` ANDed with the wrapper's own reset.

## Test plan
- Reset, no stimulus, 50 cycles → state IDLE, `cpu_rst_n`=0, `mem_we` never high, `busy`=0, `load_error`=0.
- `host_load`, then bytes 0x03, 0x10, 0x20, 0x30, 0xA0 → exactly three `mem_we` pulses:
  - addr 0/0x10, 1/0x20, 2/0x30.
  - then `cpu_rst_n`=1 and `busy`=0.
  - each pulse lands SYNC_STAGES+2 edges after the strobe rise.
- Same as above but checksum byte 0xA1 → three writes, then `load_error`=1 and `cpu_rst_n` stays 0. A following `host_load` clears `load_error`.
- Length byte 0x00 and, separately, 0x85 → ERROR with no `mem_we`.
- Maximum load: `len`=0x7F → 127 writes at addresses 0..126 with no wrap. The correct checksum gives RUN.
- Edge cases:
  - `host_load` in RUN → `cpu_rst_n` drops immediately.
  - `host_load` coincident with a strobe → no write.
  - `rst` after the 2nd of 3 data bytes → IDLE, no 3rd write even if the host continues strobing.
